decode: RTL and testbench

Instruction decode stage of the arRISCado RV32I core, directly downstream of `fetch`. It takes the fetched instruction and its PC, decodes the instruction, and reads two operands from a 32×32 register file. Immediates are extracted and sign-extended. All of this is captured in the ID/EX pipeline register, which feeds the execute stage. The write-back stage writes the register file through a dedicated port. The block also supports pipeline stall and flush.

---
 rtl/decode.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_decode.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// decode: RV32I instruction-decode stage for the arRISCado core.
// Reads two operands from a 32x32 register file, with same-cycle write-back
// bypass. Extracts and sign-extends the immediate and produces the ALU and
// memory control set. All of it is captured in the ID/EX register, which
// supports stall (hold) and flush (bubble).
module decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] pc_in,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [31:0] pc_out,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] imm,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic [3:0]  alu_op,
  output logic        alu_src,
  output logic        alu_a_pc,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        branch,
  output logic        jump,
  output logic        valid,
  output logic        illegal
);

  // RV32I major opcodes handled by this stage
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // ALU operation codes seen by the execute stage
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // Map funct3 (and instr[30]) to an ALU op. SUB is only reachable for
  // register-register ops; OP-IMM funct3=000 is always ADD because bit 30
  // belongs to the immediate there.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3,
                                                 input logic       alt,
                                                 input logic       sub_ok);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (alt && sub_ok) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Instruction fields
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic        w_alt;

  assign w_opcode = instr[6:0];
  assign w_rd     = instr[11:7];
  assign w_funct3 = instr[14:12];
  assign w_rs1    = instr[19:15];
  assign w_rs2    = instr[24:20];
  assign w_alt    = instr[30];

  // Sign-extended immediates for each instruction format
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  assign w_imm_i = {{20{instr[31]}}, instr[31:20]};
  assign w_imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign w_imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
  assign w_imm_u = {instr[31:12], 12'd0};
  assign w_imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};

  // Register file storage; x0 is never written so it always reads 0
  logic [31:0] r_rf [32];
  logic        w_wb_active;

  assign w_wb_active = wb_en && (wb_rd != 5'd0);

  // Register-file write port; cleared while in reset, independent of stall/flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        r_rf[i] <= 32'd0;
      end
    end else if (w_wb_active) begin
      r_rf[wb_rd] <= wb_data;
    end
  end

  // Operand reads with write-through bypass from the write-back port
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;

  // Read port 1: x0 forced to 0, otherwise bypass or array read
  always_comb begin
    w_rs1_data = 32'd0;
    if (w_rs1 == 5'd0) begin
      w_rs1_data = 32'd0;
    end else if (w_wb_active && (wb_rd == w_rs1)) begin
      w_rs1_data = wb_data;
    end else begin
      w_rs1_data = r_rf[w_rs1];
    end
  end

  // Read port 2: x0 forced to 0, otherwise bypass or array read
  always_comb begin
    w_rs2_data = 32'd0;
    if (w_rs2 == 5'd0) begin
      w_rs2_data = 32'd0;
    end else if (w_wb_active && (wb_rd == w_rs2)) begin
      w_rs2_data = wb_data;
    end else begin
      w_rs2_data = r_rf[w_rs2];
    end
  end

  // Decoded control set for the instruction currently on instr
  logic [31:0] w_imm;
  logic [3:0]  w_alu_op;
  logic        w_alu_src;
  logic        w_alu_a_pc;
  logic        w_reg_write;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_mem_to_reg;
  logic        w_branch;
  logic        w_jump;
  logic        w_illegal;

  // Opcode decode: everything defaults to 0/ADD, each opcode raises its own set
  always_comb begin
    w_imm        = 32'd0;
    w_alu_op     = ALU_ADD;
    w_alu_src    = 1'b0;
    w_alu_a_pc   = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_illegal    = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_reg_write = 1'b1;
        w_alu_op    = alu_from_funct3(w_funct3, w_alt, 1'b1);
      end
      OPC_OP_IMM: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_imm       = w_imm_i;
        w_alu_op    = alu_from_funct3(w_funct3, w_alt, 1'b0);
      end
      OPC_LOAD: begin
        w_reg_write  = 1'b1;
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
        w_alu_src    = 1'b1;
        w_imm        = w_imm_i;
      end
      OPC_STORE: begin
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
        w_imm       = w_imm_s;
      end
      OPC_BRANCH: begin
        w_branch = 1'b1;
        w_alu_op = ALU_SUB;
        w_imm    = w_imm_b;
      end
      OPC_LUI: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_alu_op    = ALU_PASSB;
        w_imm       = w_imm_u;
      end
      OPC_AUIPC: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_alu_a_pc  = 1'b1;
        w_imm       = w_imm_u;
      end
      OPC_JAL: begin
        w_reg_write = 1'b1;
        w_jump      = 1'b1;
        w_alu_src   = 1'b1;
        w_alu_a_pc  = 1'b1;
        w_imm       = w_imm_j;
      end
      OPC_JALR: begin
        w_reg_write = 1'b1;
        w_jump      = 1'b1;
        w_alu_src   = 1'b1;
        w_imm       = w_imm_i;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  // ID/EX register: reset clears, flush inserts a bubble (beats stall),
  // stall holds, otherwise load the freshly decoded instruction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_out     <= 32'd0;
      rs1_data   <= 32'd0;
      rs2_data   <= 32'd0;
      imm        <= 32'd0;
      rd         <= 5'd0;
      rs1        <= 5'd0;
      rs2        <= 5'd0;
      funct3     <= 3'd0;
      alu_op     <= 4'd0;
      alu_src    <= 1'b0;
      alu_a_pc   <= 1'b0;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_to_reg <= 1'b0;
      branch     <= 1'b0;
      jump       <= 1'b0;
      valid      <= 1'b0;
      illegal    <= 1'b0;
    end else if (flush) begin
      alu_op     <= 4'd0;
      alu_src    <= 1'b0;
      alu_a_pc   <= 1'b0;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_to_reg <= 1'b0;
      branch     <= 1'b0;
      jump       <= 1'b0;
      valid      <= 1'b0;
      illegal    <= 1'b0;
    end else if (!stall) begin
      pc_out     <= pc_in;
      rs1_data   <= w_rs1_data;
      rs2_data   <= w_rs2_data;
      imm        <= w_imm;
      rd         <= w_rd;
      rs1        <= w_rs1;
      rs2        <= w_rs2;
      funct3     <= w_funct3;
      alu_op     <= w_alu_op;
      alu_src    <= w_alu_src;
      alu_a_pc   <= w_alu_a_pc;
      reg_write  <= w_reg_write;
      mem_read   <= w_mem_read;
      mem_write  <= w_mem_write;
      mem_to_reg <= w_mem_to_reg;
      branch     <= w_branch;
      jump       <= w_jump;
      valid      <= 1'b1;
      illegal    <= w_illegal;
    end
  end

endmodule

// File: tb/tb_decode.sv
// tb_decode: scoreboard bench for the decode stage. A driver issues one
// cycle of stimulus at a time and pushes the expected ID/EX contents into a
// queue; a monitor pops one entry after every rising edge and compares it.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, pc_in, wb_data;
  logic        stall, flush, wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] pc_out, rs1_data, rs2_data, imm;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [3:0]  alu_op;
  logic        alu_src, alu_a_pc, reg_write, mem_read, mem_write, mem_to_reg;
  logic        branch, jump, valid, illegal;

  decode dut (
    .clk(clk), .rst(rst), .instr(instr), .pc_in(pc_in), .stall(stall),
    .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .pc_out(pc_out), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .alu_op(alu_op),
    .alu_src(alu_src), .alu_a_pc(alu_a_pc), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .branch(branch), .jump(jump), .valid(valid), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // control vector bit positions (packing order used for comparison)
  localparam int C_SRC = 7, C_APC = 6, C_RW = 5, C_MR = 4;
  localparam int C_MW = 3, C_M2R = 2, C_BR = 1, C_J = 0;

  typedef struct {
    logic [31:0] pc, r1, r2, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [3:0]  op;
    logic [7:0]  ctl;
    logic        valid, illegal;
    bit          care;      // data fields / alu_op meaningful
    bit          care_imm;  // immediate meaningful for this format
    string       tag;
  } exp_t;

  exp_t        q[$];
  exp_t        m_out;
  logic [31:0] m_rf [32];
  int          n_chk = 0;
  int          n_pass = 0;

  // Reference decode computed from the ISA field rules with integer arithmetic
  function automatic exp_t model_dec(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic [31:0] r1, input logic [31:0] r2,
                                     input string tag);
    exp_t e;
    int sx, v;
    logic [3:0] f3op [8];
    f3op = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    sx = ins[31] ? -1 : 0;
    e.pc = pc; e.r1 = r1; e.r2 = r2;
    e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.f3 = ins[14:12];
    e.op = 4'd0; e.ctl = 8'd0; e.valid = 1'b1; e.illegal = 1'b0;
    e.care = 1'b1; e.care_imm = 1'b1; e.imm = 32'd0; e.tag = tag;
    case (ins[6:0])
      7'h33: begin
        e.ctl[C_RW] = 1'b1; e.care_imm = 1'b0;
        e.op = f3op[ins[14:12]];
        if (ins[14:12] == 3'd0 && ins[30]) e.op = 4'd1;
        if (ins[14:12] == 3'd5 && ins[30]) e.op = 4'd7;
      end
      7'h13: begin
        e.ctl[C_RW] = 1'b1; e.ctl[C_SRC] = 1'b1;
        e.op = f3op[ins[14:12]];
        if (ins[14:12] == 3'd5 && ins[30]) e.op = 4'd7;
        v = $signed(ins) >>> 20; e.imm = v;
      end
      7'h03: begin
        e.ctl[C_RW] = 1'b1; e.ctl[C_MR] = 1'b1; e.ctl[C_M2R] = 1'b1; e.ctl[C_SRC] = 1'b1;
        v = $signed(ins) >>> 20; e.imm = v;
      end
      7'h23: begin
        e.ctl[C_MW] = 1'b1; e.ctl[C_SRC] = 1'b1;
        v = sx * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:7]); e.imm = v;
      end
      7'h63: begin
        e.ctl[C_BR] = 1'b1; e.op = 4'd1;
        v = sx * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        e.imm = v;
      end
      7'h37: begin
        e.ctl[C_RW] = 1'b1; e.ctl[C_SRC] = 1'b1; e.op = 4'd10;
        e.imm = ins & 32'hFFFF_F000;
      end
      7'h17: begin
        e.ctl[C_RW] = 1'b1; e.ctl[C_SRC] = 1'b1; e.ctl[C_APC] = 1'b1;
        e.imm = ins & 32'hFFFF_F000;
      end
      7'h6F: begin
        e.ctl[C_RW] = 1'b1; e.ctl[C_J] = 1'b1; e.ctl[C_SRC] = 1'b1; e.ctl[C_APC] = 1'b1;
        v = sx * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        e.imm = v;
      end
      7'h67: begin
        e.ctl[C_RW] = 1'b1; e.ctl[C_J] = 1'b1; e.ctl[C_SRC] = 1'b1;
        v = $signed(ins) >>> 20; e.imm = v;
      end
      default: begin
        e.illegal = 1'b1; e.care_imm = 1'b0;
      end
    endcase
    return e;
  endfunction

  // Register read as seen by the stage, including same-cycle write-back
  function automatic logic [31:0] model_read(input logic [4:0] idx, input logic we,
                                             input logic [4:0] wrd, input logic [31:0] wd);
    if (idx == 5'd0) return 32'd0;
    if (we && wrd == idx) return wd;
    return m_rf[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_out.pc = 32'd0; m_out.r1 = 32'd0; m_out.r2 = 32'd0; m_out.imm = 32'd0;
    m_out.rd = 5'd0; m_out.rs1 = 5'd0; m_out.rs2 = 5'd0; m_out.f3 = 3'd0;
    m_out.op = 4'd0; m_out.ctl = 8'd0; m_out.valid = 1'b0; m_out.illegal = 1'b0;
    m_out.care = 1'b1; m_out.care_imm = 1'b1; m_out.tag = "reset";
  endtask

  // One clock of stimulus: drive inputs, push expectation, advance to edge+3
  task automatic cycle(input logic [31:0] ins, input logic [31:0] pc, input logic st,
                       input logic fl, input logic we, input logic [4:0] wrd,
                       input logic [31:0] wd, input string tag);
    exp_t e;
    instr = ins; pc_in = pc; stall = st; flush = fl;
    wb_en = we; wb_rd = wrd; wb_data = wd;
    if (fl) begin
      e = m_out;
      e.ctl = 8'd0; e.valid = 1'b0; e.illegal = 1'b0;
      e.care = 1'b0; e.care_imm = 1'b0;
    end else if (st) begin
      e = m_out;
    end else begin
      e = model_dec(ins, pc, model_read(ins[19:15], we, wrd, wd),
                    model_read(ins[24:20], we, wrd, wd), tag);
    end
    e.tag = tag;
    m_out = e;
    q.push_back(e);
    if (we && wrd != 5'd0) m_rf[wrd] = wd;
    @(posedge clk);
    #3;
  endtask

  task automatic check_out(input exp_t e);
    bit ok;
    logic [7:0] c;
    c = {alu_src, alu_a_pc, reg_write, mem_read, mem_write, mem_to_reg, branch, jump};
    ok = (valid === e.valid) && (illegal === e.illegal) && (c === e.ctl);
    if (e.care)
      ok = ok && (pc_out === e.pc) && (rs1_data === e.r1) && (rs2_data === e.r2) &&
           (rd === e.rd) && (rs1 === e.rs1) && (rs2 === e.rs2) &&
           (funct3 === e.f3) && (alu_op === e.op);
    if (e.care_imm) ok = ok && (imm === e.imm);
    n_chk++;
    if (ok) n_pass++;
    else
      $display("FAIL %s: got v=%b ill=%b ctl=%b op=%0d imm=%h pc=%h r1=%h r2=%h rd=%0d f3=%0d | exp v=%b ill=%b ctl=%b op=%0d imm=%h pc=%h r1=%h r2=%h rd=%0d f3=%0d",
               e.tag, valid, illegal, c, alu_op, imm, pc_out, rs1_data, rs2_data, rd, funct3,
               e.valid, e.illegal, e.ctl, e.op, e.imm, e.pc, e.r1, e.r2, e.rd, e.f3);
  endtask

  task automatic check_zero(input string tag);
    logic [207:0] all;
    all = {pc_out, rs1_data, rs2_data, imm, rd, rs1, rs2, funct3, alu_op, alu_src,
           alu_a_pc, reg_write, mem_read, mem_write, mem_to_reg, branch, jump,
           valid, illegal};
    n_chk++;
    if (all === '0) n_pass++;
    else $display("FAIL %s: outputs not all zero in reset, got %h", tag, all);
  endtask

  task automatic rand_inputs();
    instr = $urandom; pc_in = $urandom; stall = 1'($urandom); flush = 1'($urandom);
    wb_en = 1'b1; wb_rd = 5'($urandom_range(1, 31)); wb_data = $urandom;
  endtask

  // Monitor: after each rising edge, pop one expectation and compare
  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) check_out(q.pop_front());
  end

  logic [31:0] r_ins;
  logic [31:0] r_pc;
  logic [6:0]  opc [10];

  initial begin
    opc = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};
    rst = 1'b0;
    rand_inputs();
    model_reset();
    #1 check_zero("reset_t0");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check_zero("reset_held");
      rand_inputs();
    end
    #2 rst = 1'b1;

    // reset release and first decode
    cycle(32'h0050_0093, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, "addi_after_reset");
    // register file write then read, then same-cycle bypass
    cycle(32'h0000_0013, 32'd1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, "wb_x5");
    cycle(32'h0002_8333, 32'd2, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, "add_read_x5");
    cycle(32'h0004_0333, 32'd3, 1'b0, 1'b0, 1'b1, 5'd8, 32'hDEAD_BEEF, "add_bypass_x8");
    cycle(32'h0000_0013, 32'd4, 1'b0, 1'b0, 1'b1, 5'd0, 32'd7, "wb_x0");
    cycle(32'h0000_0333, 32'd5, 1'b0, 1'b0, 1'b1, 5'd0, 32'd9, "read_x0");
    // immediates
    cycle(32'hFE00_0EE3, 32'd6, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, "beq_m4");
    cycle(32'h1234_5137, 32'd7, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, "lui");
    cycle(32'h0080_00EF, 32'd8, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, "jal_8");
    // stall with a changing instr, then release
    cycle(32'h4020_81B3, 32'd9, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, "sub");
    for (int i = 0; i < 3; i++)
      cycle($urandom, $urandom, 1'b1, 1'b0, 1'b1, 5'd1, $urandom, "sub_stalled");
    cycle(32'h0020_A023, 32'd10, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, "sw_after_stall");
    // flush beats stall
    cycle(32'h0020_A023, 32'd11, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, "flush_with_stall");
    cycle(32'h0020_A023, 32'd11, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, "bubble_stalled");
    cycle(32'h0020_A023, 32'd11, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, "flush_2");
    // illegal and load
    cycle(32'h0000_007F, 32'd12, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, "illegal");
    cycle(32'h0040_A183, 32'd13, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, "lw");

    // reset mid-stall clears immediately
    cycle(32'h4020_81B3, 32'd14, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, "pre_reset_stall");
    rst = 1'b0;
    #1 check_zero("reset_mid_stall");
    rand_inputs();
    @(posedge clk);
    #1 check_zero("reset_mid_stall_edge");
    model_reset();
    #2 rst = 1'b1;
    cycle(32'h0002_8333, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, "x5_cleared_by_reset");
    // reset mid-flush
    cycle(32'h0020_A023, 32'd1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, "pre_reset_flush");
    rst = 1'b0;
    #1 check_zero("reset_mid_flush");
    model_reset();
    #2 rst = 1'b1;
    @(posedge clk);
    #3;

    // randomized traffic; upstream holds instr/pc stable while stalled
    r_pc = 32'd0;
    r_ins = 32'h0000_0013;
    for (int i = 0; i < 500; i++) begin
      logic st, fl;
      st = ($urandom_range(0, 5) == 0);
      fl = ($urandom_range(0, 9) == 0);
      if (!st) begin
        r_ins = $urandom;
        r_ins[6:0] = opc[$urandom_range(0, 9)];
        r_pc = r_pc + 32'd1;
      end
      cycle(r_ins, r_pc, st, fl, 1'($urandom), 5'($urandom), $urandom, "random");
    end

    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, required 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
